card_shoe: RTL

Card source for the blackjack datapath. It holds one 52-card deck as a used-card bitmask and draws a pseudo-random, never-repeating card on each request. Each dealt card is presented as rank, suit and blackjack value, and the shoe reshuffles when it runs empty. It sits directly upstream of the game FSM: the FSM pulses `deal_req` whenever a player or dealer card is needed and consumes the card on `deal_valid`.

---
 rtl/card_pkg.sv | 40 ++++
 rtl/card_shoe_lfsr.sv | 32 +++
 rtl/card_shoe.sv | 119 +++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared card definitions for the blackjack datapath: deck constants, shoe
// states, the dealt-card record and index/rank decoding helpers.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PROBE   = 2'd1,
        S_DEAL    = 2'd2,
        S_SHUFFLE = 2'd3
    } shoe_state_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
        logic [3:0] value;
    } card_t;

    // Face cards count ten; the ace stays 1 and soft-11 is left to the game FSM.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        logic [3:0] v;
        if (rank > 4'd10) begin
            v = 4'd10;
        end else begin
            v = rank;
        end
        return v;
    endfunction

    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t c;
        c.suit  = 2'(idx / 6'(RANKS));
        c.rank  = 4'(idx % 6'(RANKS)) + 4'd1;
        c.value = rank_to_value(c.rank);
        return c;
    endfunction

endpackage

// File: rtl/card_shoe_lfsr.sv
// Free-running 16-bit Fibonacci LFSR with its low bits folded into a 0..51
// candidate card index.
module shoe_lfsr
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] o_candidate
);

    logic [15:0] r_lfsr;
    logic        w_feedback;
    logic [5:0]  w_low;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting form.
    assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_low      = r_lfsr[5:0];

    // Steps every clock regardless of what the shoe is doing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {w_feedback, r_lfsr[15:1]};
        end
    end

    assign o_candidate = (w_low >= 6'(DECK_SIZE)) ? (w_low - 6'(DECK_SIZE)) : w_low;

endmodule

// File: rtl/card_shoe.sv
// Single-deck card shoe: draws a non-repeating pseudo-random card per request
// using a used-card mask and linear probing, and reshuffles when empty.
module card_shoe
    import card_pkg::*;
#(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          LOW_THRESHOLD = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_deal_req,
    input  logic       i_shuffle_req,
    output logic       o_ready,
    output logic       o_deal_valid,
    output logic [3:0] o_card_rank,
    output logic [1:0] o_card_suit,
    output logic [3:0] o_card_value,
    output logic [5:0] o_cards_left,
    output logic       o_low_shoe,
    output logic       o_reshuffled
);

    shoe_state_t            r_state;
    logic [DECK_SIZE-1:0]   r_mask;
    logic [5:0]             r_ptr;
    logic [5:0]             r_cards_left;
    logic                   r_pending_deal;
    logic                   r_ready;
    logic                   r_deal_valid;
    logic                   r_reshuffled;
    card_t                  r_card;
    logic [5:0]             w_candidate;
    logic [5:0]             w_ptr_next;

    shoe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk         (clk),
        .reset       (reset),
        .o_candidate (w_candidate)
    );

    assign w_ptr_next = (r_ptr == 6'(DECK_SIZE - 1)) ? 6'd0 : (r_ptr + 6'd1);

    // Shoe controller; a shuffle takes effect on the accepting edge so the
    // refilled count and the reshuffled pulse appear in the SHUFFLE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mask         <= '0;
            r_ptr          <= 6'd0;
            r_cards_left   <= 6'(DECK_SIZE);
            r_pending_deal <= 1'b0;
            r_ready        <= 1'b1;
            r_deal_valid   <= 1'b0;
            r_reshuffled   <= 1'b0;
            r_card         <= '0;
        end else begin
            r_deal_valid <= 1'b0;
            r_reshuffled <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_shuffle_req || (i_deal_req && (r_cards_left == 6'd0))) begin
                        r_mask         <= '0;
                        r_cards_left   <= 6'(DECK_SIZE);
                        r_reshuffled   <= 1'b1;
                        r_pending_deal <= ~i_shuffle_req;
                        r_ready        <= 1'b0;
                        r_state        <= S_SHUFFLE;
                    end else if (i_deal_req) begin
                        r_ptr   <= w_candidate;
                        r_ready <= 1'b0;
                        r_state <= S_PROBE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_PROBE: begin
                    if (r_mask[r_ptr]) begin
                        r_ptr <= w_ptr_next;
                    end else begin
                        r_mask[r_ptr] <= 1'b1;
                        r_cards_left  <= r_cards_left - 6'd1;
                        r_card        <= idx_to_card(r_ptr);
                        r_deal_valid  <= 1'b1;
                        r_state       <= S_DEAL;
                    end
                end
                S_DEAL: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_SHUFFLE: begin
                    if (r_pending_deal) begin
                        r_pending_deal <= 1'b0;
                        r_ptr          <= w_candidate;
                        r_state        <= S_PROBE;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_pending_deal <= 1'b0;
                    r_ready        <= 1'b1;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_deal_valid = r_deal_valid;
    assign o_card_rank  = r_card.rank;
    assign o_card_suit  = r_card.suit;
    assign o_card_value = r_card.value;
    assign o_cards_left = r_cards_left;
    assign o_low_shoe   = (r_cards_left <= 6'(LOW_THRESHOLD));
    assign o_reshuffled = r_reshuffled;

endmodule
